// File: rtl/jam_pkg.sv
// Shared JAM definitions: widths, table geometry and the cost-server FSM states.
// No ports; imported by the cost server, its table and the JAM solver.
package jam_pkg;

    localparam int COST_W      = 7;
    localparam int MIN_W       = 10;
    localparam int CNT_W       = 4;
    localparam int ACC_W       = 16;
    localparam int NUM_W       = 8;
    localparam int NUM_J       = 8;
    localparam int TABLE_DEPTH = 64;
    localparam int IDX_W       = $clog2(TABLE_DEPTH);

    typedef enum logic [1:0] {
        LOAD,
        RELEASE,
        SERVE,
        DONE
    } jam_state_e;

endpackage

// File: rtl/jam_cost_server_if.sv
// Bundles the serial load port and the JAM query/result port of the cost server.
// slave: cost-server view; master: loader + solver view.
interface jam_cost_server_if;

    logic                        ld_valid;
    logic                        ld_ready;
    logic [jam_pkg::COST_W-1:0]  ld_data;
    logic [2:0]                  W;
    logic [2:0]                  J;
    logic [jam_pkg::COST_W-1:0]  Cost;
    logic                        Valid;
    logic [jam_pkg::MIN_W-1:0]   MinCost;
    logic [jam_pkg::CNT_W-1:0]   MatchCount;
    logic                        jam_rst;

    modport slave (
        input  ld_valid, ld_data, W, J, Valid, MinCost, MatchCount,
        output ld_ready, Cost, jam_rst
    );

    modport master (
        output ld_valid, ld_data, W, J, Valid, MinCost, MatchCount,
        input  ld_ready, Cost, jam_rst
    );

endinterface

// File: rtl/jam_cost_table.sv
// 64 x COST_W cost storage: one synchronous write port, one combinational read.
// Ports: CLK, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (read). Not reset.
module jam_cost_table
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [COST_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [COST_W-1:0] rdata_o
);

    logic [COST_W-1:0] mem_q [TABLE_DEPTH];

    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jam_cost_server.sv
// JAM cost server: serial table load, zero-latency (W,J)->Cost, result capture.
// Ports: CLK, RST (async, active-high), bus (jam_cost_server_if.slave),
// restart, res_valid/res_min/res_match, busy, access_cnt.
// Macro JAM_ACCESS_COUNT_EN enables the SERVE-cycle counter on access_cnt.
module jam_cost_server
    import jam_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    jam_cost_server_if.slave   bus,
    input  logic               restart,
    output logic               res_valid,
    output logic [MIN_W-1:0]   res_min,
    output logic [CNT_W-1:0]   res_match,
    output logic               busy,
    output logic [ACC_W-1:0]   access_cnt
);

    jam_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               we;
    logic               ld_ready_q;
    logic               jam_rst_q;
    logic               busy_q;
    logic               res_valid_q;
    logic [MIN_W-1:0]   res_min_q;
    logic [CNT_W-1:0]   res_match_q;
    logic [COST_W-1:0]  rdata;
    logic               capture;

    jam_cost_table u_table (
        .CLK     (CLK),
        .we_i    (we),
        .waddr_i (idx_q),
        .wdata_i (bus.ld_data),
        .raddr_i ({bus.W, bus.J}),
        .rdata_o (rdata)
    );

    assign capture = (state_q == SERVE) && bus.Valid;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we      = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (bus.ld_valid) begin
                    we    = 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_W'(TABLE_DEPTH - 1)) begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: state_d = SERVE;
            SERVE: begin
                if (bus.Valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (restart) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
        endcase
    end

    // Handshake/reset outputs are decoded from the next state so they
    // change on the same edge as the state and never glitch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            ld_ready_q  <= 1'b1;
            jam_rst_q   <= 1'b1;
            busy_q      <= 1'b1;
            res_valid_q <= 1'b0;
            res_min_q   <= '0;
            res_match_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ld_ready_q  <= (state_d == LOAD);
            jam_rst_q   <= (state_d != SERVE);
            busy_q      <= (state_d != DONE);
            res_valid_q <= capture;
            if (capture) begin
                res_min_q   <= bus.MinCost;
                res_match_q <= bus.MatchCount;
            end
        end
    end

    assign bus.ld_ready = ld_ready_q;
    assign bus.jam_rst  = jam_rst_q;
    assign bus.Cost     = (state_q == SERVE) ? rdata : '0;
    assign busy         = busy_q;
    assign res_valid    = res_valid_q;
    assign res_min      = res_min_q;
    assign res_match    = res_match_q;

`ifdef JAM_ACCESS_COUNT_EN
    logic [ACC_W-1:0] acc_q;

    // RELEASE always leads to SERVE, so clearing there clears on entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q <= '0;
        end else if (state_q == RELEASE) begin
            acc_q <= '0;
        end else if ((state_q == SERVE) && (acc_q != '1)) begin
            acc_q <= acc_q + 1'b1;
        end
    end

    assign access_cnt = acc_q;
`else
    assign access_cnt = '0;
`endif

endmodule

// File: tb/tb_jam_cost_server.sv
// Randomized self-checking bench for jam_cost_server against a phase-level model.
// Honours JAM_ACCESS_COUNT_EN for the access_cnt expectation.
module tb_jam_cost_server;

    localparam int CW = jam_pkg::COST_W;
    localparam int MW = jam_pkg::MIN_W;
    localparam int NW = jam_pkg::CNT_W;
    localparam int AW = jam_pkg::ACC_W;

    logic          CLK = 1'b0;
    logic          RST;
    logic          restart;
    logic          res_valid;
    logic [MW-1:0] res_min;
    logic [NW-1:0] res_match;
    logic          busy;
    logic [AW-1:0] access_cnt;

    always #5 CLK = ~CLK;

    jam_cost_server_if bus ();

    jam_cost_server dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus),
        .restart    (restart),
        .res_valid  (res_valid),
        .res_min    (res_min),
        .res_match  (res_match),
        .busy       (busy),
        .access_cnt (access_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit run_cmp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {P_LOAD, P_REL, P_SERVE, P_DONE} phase_e;
    phase_e      ph;
    int          idx;
    logic [CW-1:0] mmem [64];
    bit          m_rv;
    int          m_min;
    int          m_match;
    int          m_acc;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ph = P_LOAD; idx = 0; m_rv = 0;
            m_min = 0; m_match = 0; m_acc = 0;
        end else begin
            m_rv = 0;
            case (ph)
                P_LOAD: if (bus.ld_valid) begin
                    mmem[idx] = bus.ld_data;
                    if (idx == 63) ph = P_REL;
                    idx = (idx + 1) % 64;
                end
                P_REL: begin
                    ph = P_SERVE;
                    m_acc = 0;
                end
                P_SERVE: begin
                    if (m_acc < (1 << AW) - 1) m_acc++;
                    if (bus.Valid) begin
                        m_min = int'(bus.MinCost);
                        m_match = int'(bus.MatchCount);
                        m_rv = 1;
                        ph = P_DONE;
                    end
                end
                P_DONE: if (restart) begin
                    ph = P_LOAD;
                    idx = 0;
                end
            endcase
        end
    end

    always @(negedge CLK) begin
        if (run_cmp) begin
            chk("ld_ready", 32'(bus.ld_ready), 32'(ph == P_LOAD));
            chk("jam_rst", 32'(bus.jam_rst), 32'(ph != P_SERVE));
            chk("busy", 32'(busy), 32'(ph != P_DONE));
            chk("Cost", 32'(bus.Cost),
                (ph == P_SERVE) ? 32'(mmem[{bus.W, bus.J}]) : 32'd0);
            chk("res_valid", 32'(res_valid), 32'(m_rv));
            chk("res_min", 32'(res_min), 32'(m_min));
            chk("res_match", 32'(res_match), 32'(m_match));
`ifdef JAM_ACCESS_COUNT_EN
            chk("access_cnt", 32'(access_cnt), 32'(m_acc));
`else
            chk("access_cnt", 32'(access_cnt), 32'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic rnd_wj();
        bus.W = 3'($urandom);
        bus.J = 3'($urandom);
    endtask

    // mode 0: ld_valid held high; 1: toggling. kind 0: k%128, 1: random, 2: 0x55
    task automatic load_table(input int mode, input int kind, output int cycles);
        bit tog = 1'b1;
        cycles = 0;
        while (ph == P_LOAD && cycles < 400) begin
            bus.ld_valid = (mode == 0) ? 1'b1 : tog;
            tog = !tog;
            bus.ld_data = (kind == 0) ? CW'(idx % 128) :
                          (kind == 1) ? CW'($urandom) : CW'(7'h55);
            rnd_wj();
            bus.Valid = 1'($urandom);
            bus.MinCost = MW'($urandom);
            bus.MatchCount = NW'($urandom);
            restart = 1'($urandom);
            cyc();
            cycles++;
        end
        bus.ld_valid = 1'b0;
        bus.Valid = 1'b0;
        restart = 1'b0;
        if (ph == P_LOAD) begin
            n_cmp++;
            n_bad++;
            $display("FAIL load_timeout: got %0d words, expected 64", idx);
        end
    endtask

    task automatic wait_serve();
        int g = 0;
        while (ph != P_SERVE && g < 10) begin
            cyc();
            g++;
        end
        chk("reach_serve", 32'(ph == P_SERVE), 32'd1);
    endtask

    int ncyc;

    initial begin
        RST = 1'b1;
        restart = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data = '0;
        bus.W = '0;
        bus.J = '0;
        bus.Valid = 1'b0;
        bus.MinCost = '0;
        bus.MatchCount = '0;
        cyc();
        run_cmp = 1'b1;
        cyc();
        cyc();
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("rst_jam_rst", 32'(bus.jam_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_cost", 32'(bus.Cost), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_access", 32'(access_cnt), 32'd0);
        RST = 1'b0;

        // Table 1: k mod 128, ld_valid held high
        load_table(0, 0, ncyc);
        chk("load_cycles_hold", 32'(ncyc), 32'd64);
        chk("release_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("release_jam_rst", 32'(bus.jam_rst), 32'd1);
        cyc();
        chk("serve_jam_rst", 32'(bus.jam_rst), 32'd0);
        bus.W = 3'd3; bus.J = 3'd5; #1;
        chk("cost_3_5", 32'(bus.Cost), 32'd29);
        bus.W = 3'd7; bus.J = 3'd7; #1;
        chk("cost_7_7", 32'(bus.Cost), 32'd63);
        for (int i = 0; i < 30; i++) begin
            rnd_wj();
            bus.ld_valid = 1'($urandom);
            bus.ld_data = CW'($urandom);
            restart = 1'($urandom);
            cyc();
        end
        bus.ld_valid = 1'b0;
        restart = 1'b0;

        // Capture, then a second Valid in DONE must be ignored
        bus.Valid = 1'b1; bus.MinCost = 10'd312; bus.MatchCount = 4'd3;
        cyc();
        bus.Valid = 1'b0;
        chk("cap_res_valid", 32'(res_valid), 32'd1);
        chk("cap_res_min", 32'(res_min), 32'd312);
        chk("cap_res_match", 32'(res_match), 32'd3);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_jam_rst", 32'(bus.jam_rst), 32'd1);
        bus.Valid = 1'b1; bus.MinCost = 10'd5; bus.MatchCount = 4'd9;
        cyc();
        bus.Valid = 1'b0;
        chk("second_valid_pulse", 32'(res_valid), 32'd0);
        chk("second_valid_min", 32'(res_min), 32'd312);

        // Table 2: random data, toggling ld_valid
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        load_table(1, 1, ncyc);
        chk("load_cycles_toggle", 32'(ncyc), 32'd127);
        chk("hold_res_min", 32'(res_min), 32'd312);
        chk("hold_res_match", 32'(res_match), 32'd3);
        wait_serve();
        for (int k = 0; k < 64; k++) begin
            bus.W = 3'(k >> 3);
            bus.J = 3'(k);
            bus.ld_valid = 1'(k);
            bus.ld_data = CW'($urandom);
            cyc();
        end
        bus.ld_valid = 1'b0;
        bus.Valid = 1'b1;
        bus.MinCost = MW'($urandom);
        bus.MatchCount = NW'($urandom);
        cyc();
        bus.Valid = 1'b0;
        chk("cap2_res_valid", 32'(res_valid), 32'd1);

        // Abort a load with RST after 20 words, then reload 0x55
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data = CW'($urandom);
            cyc();
        end
        bus.ld_valid = 1'b0;
        RST = 1'b1;
        #1;
        chk("abort_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("abort_jam_rst", 32'(bus.jam_rst), 32'd1);
        chk("abort_res_min", 32'(res_min), 32'd0);
        cyc();
        RST = 1'b0;
        load_table(0, 2, ncyc);
        chk("reload_cycles", 32'(ncyc), 32'd64);
        wait_serve();
        for (int i = 0; i < 999; i++) begin
            if (i < 64) begin
                bus.W = 3'(i >> 3);
                bus.J = 3'(i);
                #1;
                chk("cost_55", 32'(bus.Cost), 32'h55);
            end else begin
                rnd_wj();
            end
            cyc();
        end
        bus.Valid = 1'b1;
        bus.MinCost = 10'd777;
        bus.MatchCount = 4'd8;
        cyc();
        bus.Valid = 1'b0;
        chk("cap3_res_min", 32'(res_min), 32'd777);
`ifdef JAM_ACCESS_COUNT_EN
        chk("access_1000", 32'(access_cnt), 32'd1000);
`else
        chk("access_off", 32'(access_cnt), 32'd0);
`endif
        cyc();
        cyc();
        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
